// File: rtl/sram_if_pkg.sv
// Shared types for the SRAM-like bus responder: size codes, service states,
// queued request entry and the byte-enable helper.
package sram_if_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } svc_state_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_entry_t;

   // Reserved size code behaves like a full word.
   function automatic logic [3:0] size_to_be(
      input logic [1:0] size,
      input logic [1:0] addr_lo
   );
      logic [3:0] be;
      be = 4'b1111;
      unique case (1'b1)
         (size == SZ_BYTE): be = 4'b0001 << addr_lo;
         (size == SZ_HALF): be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:           be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// In-order request queue for the responder; push and pop may share a cycle.
// Caller never pushes when full nor pops when empty.
module sram_req_fifo
   import sram_if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           push,
   input  logic                           pop,
   input  req_entry_t                     din,
   output req_entry_t                     dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   req_entry_t    slots [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = slots[rptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= bump(wptr);
         if (pop)  rptr <= bump(rptr);
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) slots[wptr] <= din;
   end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like req/addr_ok/data_ok bus.
// Optional RESP_RANDOM_DELAY_EN adds 0..3 LFSR-driven wait cycles per entry.
module sram_like_responder
   import sram_if_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int LATENCY     = 1,
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic [31:0] rdata,
   output logic        data_ok
);

   localparam int         CW   = $clog2(OUTSTANDING + 1);
   localparam logic [4:0] LOAD = 5'(LATENCY - 1);

   req_entry_t        din;
   req_entry_t        head;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic              push;
   logic              fire;
   logic              active;
   logic              has_next;
   svc_state_t        state;
   svc_state_t        state_n;
   logic [4:0]        cnt;
   logic [4:0]        cnt_n;
   logic [1:0]        extra;
   logic [ADDR_W-1:0] widx;
   logic [31:0]       mem [2**ADDR_W];
   logic              unused_bits;

   assign addr_ok = resetn & ~full;
   assign push    = req & addr_ok;
   assign din     = '{wr: wr, size: size, addr: addr, wdata: wdata,
                      be: size_to_be(size, addr[1:0])};
   assign widx    = head.addr[ADDR_W+1:2];
   assign unused_bits = ^{head.size, head.addr[31:ADDR_W+2], head.addr[1:0]};

   sram_req_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (fire),
      .din    (din),
      .dout   (head),
      .full   (full),
      .empty  (empty),
      .count  (count)
   );

`ifdef RESP_RANDOM_DELAY_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (!resetn) lfsr <= 8'hA5;
      else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign extra = lfsr[1:0];
`else
   assign extra = 2'b00;
`endif

   // Head counts down while WAITing, or during RESP when a successor is queued.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      active   = (state == WAIT) | ((state == RESP) & ~empty);
      fire     = resetn & active & (cnt == '0);
      has_next = (count > CW'(1)) | push;
      if (fire) begin
         state_n = RESP;
         if (has_next) cnt_n = LOAD + {3'b000, extra};
      end else if (active) begin
         state_n = WAIT;
         cnt_n   = cnt - 5'd1;
      end else if (push) begin
         state_n = WAIT;
         cnt_n   = LOAD + {3'b000, extra};
      end else begin
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         data_ok <= 1'b0;
         rdata   <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         data_ok <= fire;
         if (fire && !head.wr) rdata <= mem[widx];
      end
   end

   always_ff @(posedge clk) begin
      if (fire && head.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (head.be[b]) mem[widx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: LATENCY=3 and LATENCY=1 instances,
// vector table plus back-to-back, reset-abort and randomized model checks.
module tb_sram_like_responder;

`ifdef RESP_RANDOM_DELAY_EN
   localparam int XMAX = 3;
`else
   localparam int XMAX = 0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        req;
   logic        wr;
   logic        sel;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ao3, dok3, ao1, dok1;
   logic [31:0] rd3, rd1;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   sram_like_responder #(.ADDR_W(12), .LATENCY(3), .OUTSTANDING(2)) u_l3 (
      .clk (clk), .resetn (resetn), .req (req & ~sel), .wr (wr),
      .size (size), .addr (addr), .wdata (wdata),
      .addr_ok (ao3), .rdata (rd3), .data_ok (dok3)
   );

   sram_like_responder #(.ADDR_W(12), .LATENCY(1), .OUTSTANDING(2)) u_l1 (
      .clk (clk), .resetn (resetn), .req (req & sel), .wr (wr),
      .size (size), .addr (addr), .wdata (wdata),
      .addr_ok (ao1), .rdata (rd1), .data_ok (dok1)
   );

   assign addr_ok = sel ? ao1 : ao3;
   assign data_ok = sel ? dok1 : dok3;
   assign rdata   = sel ? rd1 : rd3;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int v,
                            input int lo, input int hi);
      n_cmp++;
      if (v < lo || v > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
      end
   endtask

   // One isolated transaction; returns rdata at data_ok and cycles from accept.
   task automatic xact(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
      int t;
      req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
      t = 0;
      while (!addr_ok && t < 50) begin
         tick;
         t++;
      end
      if (!addr_ok) check("accept_timeout", 32'(t), 32'(0));
      tick;
      req = 1'b0;
      lat = 0;
      do begin
         tick;
         lat++;
      end while (!data_ok && lat < 50);
      r = rdata;
   endtask

   function automatic bit lane(input logic [1:0] sz, input logic [1:0] lo,
                               input int b);
      case (sz)
         2'd0:    return b == int'(lo);
         2'd1:    return (b / 2) == int'(lo[1]);
         default: return 1'b1;
      endcase
   endfunction

   // 4 writes then 4 reads issued back to back with req held.
   task automatic b2b(input int lat_min, input logic [31:0] base);
      logic [31:0] exp_q [$];
      bit          rd_q  [$];
      int          acc_q [$];
      int          outst, idx, cyc, nresp, lat;
      logic        hs;
      logic [31:0] e;
      bit          isrd;
      idx = 0; outst = 0; nresp = 0; cyc = 0;
      req = 1'b1; wr = 1'b1; size = 2'd2; addr = base; wdata = base ^ 32'h5A5A0000;
      while (nresp < 8 && cyc < 200) begin
         check("b2b_addr_ok", 32'(addr_ok), 32'(outst < 2));
         hs = req & addr_ok;
         tick;
         cyc++;
         if (hs) begin
            acc_q.push_back(cyc);
            rd_q.push_back(idx >= 4);
            exp_q.push_back((base + 32'(4 * (idx % 4))) ^ 32'h5A5A0000);
            outst++;
            idx++;
         end
         if (data_ok) begin
            if (acc_q.size() == 0) begin
               check("b2b_spurious", 32'(1), 32'(0));
            end else begin
               lat  = cyc - acc_q.pop_front();
               isrd = rd_q.pop_front();
               e    = exp_q.pop_front();
               outst--;
               check_rng("b2b_latency", lat, lat_min,
                         (lat_min == 1 && XMAX == 0) ? 1 : 100);
               if (isrd) check("b2b_rdata", rdata, e);
            end
            nresp++;
         end
         if (idx < 8) begin
            wr    = (idx < 4);
            addr  = base + 32'(4 * (idx % 4));
            wdata = addr ^ 32'h5A5A0000;
         end else begin
            req = 1'b0;
         end
      end
      check("b2b_responses", 32'(nresp), 32'(8));
      if (lat_min == 1 && XMAX == 0) check("b2b_throughput", 32'(cyc), 32'(9));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int          lat;
      logic [31:0] ref_m [16];

      tbl[0]  = '{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h00000000};
      tbl[1]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 2'd2, 32'h10,   32'h11223344, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 2'd0, 32'h13,   32'hAA998877, 32'hDEADBEEF};
      tbl[4]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'hAA223344};
      tbl[5]  = '{1'b1, 2'd1, 32'h12,   32'h55661234, 32'hAA223344};
      tbl[6]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h55663344};
      tbl[7]  = '{1'b1, 2'd0, 32'h10,   32'h123456EE, 32'h55663344};
      tbl[8]  = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h556633EE};
      tbl[9]  = '{1'b1, 2'd1, 32'h11,   32'h9999BBCC, 32'h556633EE};
      tbl[10] = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h5566BBCC};
      tbl[11] = '{1'b1, 2'd3, 32'h12,   32'h01020304, 32'h5566BBCC};
      tbl[12] = '{1'b0, 2'd2, 32'h4010, 32'h0,        32'h01020304};
      tbl[13] = '{1'b1, 2'd2, 32'h20,   32'h12345678, 32'h01020304};
      tbl[14] = '{1'b0, 2'd0, 32'h21,   32'h0,        32'h12345678};
      tbl[15] = '{1'b0, 2'd2, 32'h10,   32'h0,        32'h01020304};

      sel = 1'b0; resetn = 1'b0; req = 1'b1; wr = 1'b1;
      size = 2'd2; addr = 32'h10; wdata = 32'hFFFFFFFF;

      repeat (3) begin
         tick;
         check("rst_addr_ok", 32'(addr_ok), 32'(0));
         check("rst_data_ok", 32'(data_ok), 32'(0));
         check("rst_rdata", rdata, 32'h0);
      end
      req = 1'b0;
      resetn = 1'b1;
      tick;
      check("rel_addr_ok", 32'(addr_ok), 32'(1));
      check("rel_data_ok", 32'(data_ok), 32'(0));

      for (int i = 0; i < 16; i++) begin
         xact(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, r, lat);
         check_rng($sformatf("vec%0d_latency", i), lat, 3, 3 + XMAX);
         check($sformatf("vec%0d_rdata", i), r, tbl[i].exp);
      end

      sel = 1'b1;
      tick;
      b2b(1, 32'h100);
      sel = 1'b0;
      tick;
      b2b(3, 32'h200);

      req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFEF00D;
      check("abort_addr_ok", 32'(addr_ok), 32'(1));
      tick;
      req = 1'b0;
      repeat (2) begin
         tick;
         check("abort_pre_data_ok", 32'(data_ok), 32'(0));
      end
      resetn = 1'b0;
      repeat (2) begin
         tick;
         check("abort_rst_data_ok", 32'(data_ok), 32'(0));
      end
      resetn = 1'b1;
      repeat (6) begin
         tick;
         check("abort_post_data_ok", 32'(data_ok), 32'(0));
      end
      xact(1'b0, 2'd2, 32'h20, 32'h0, r, lat);
      check("abort_read_old", r, 32'h12345678);
      last_rd = r;

      for (int k = 0; k < 16; k++) begin
         ref_m[k] = $urandom;
         xact(1'b1, 2'd2, 32'h300 + 32'(4 * k), ref_m[k], r, lat);
         check_rng("rnd_init_latency", lat, 3, 3 + XMAX);
         check("rnd_init_rdata_hold", r, last_rd);
      end
      for (int n = 0; n < 60; n++) begin
         int          k;
         logic        w;
         logic [1:0]  sz, lo;
         logic [31:0] a, d;
         k  = int'($urandom_range(0, 15));
         w  = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         lo = 2'($urandom_range(0, 3));
         a  = 32'h300 + 32'(4 * k) + 32'(lo) + (32'($urandom_range(0, 3)) << 14);
         d  = $urandom;
         xact(w, sz, a, d, r, lat);
         check_rng("rnd_latency", lat, 3, 3 + XMAX);
         if (w) begin
            check("rnd_wr_rdata_hold", r, last_rd);
            for (int b = 0; b < 4; b++) begin
               if (lane(sz, lo, b)) ref_m[k][8*b +: 8] = d[8*b +: 8];
            end
         end else begin
            check("rnd_rd_rdata", r, ref_m[k]);
            last_rd = ref_m[k];
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
